// File: rtl/key_scan_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, FSM states,
// and the {valid, code} key-state encoding where valid = 0 means NONE.
package key_scan_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_EVAL = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] code;
    } key_state_t;

    localparam key_state_t KEY_NONE = '{valid: 1'b0, code: '0};

    // NONE always carries code 0 so that key states compare with plain ==.
    function automatic key_state_t decode_hits(
        input logic [NUM_COLS-1:0][NUM_ROWS-1:0] hit
    );
        key_state_t  res;
        int unsigned cnt;
        res = KEY_NONE;
        cnt = 0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                if (hit[c][r]) begin
                    cnt++;
                    res.code = KEY_W'(r * NUM_COLS + c);
                end
            end
        end
        res.valid = (cnt == 1);
        if (cnt != 1) begin
            res.code = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_scan_sync.sv
// Parameterised-width 2-flop synchronizer, resetting to all-ones so that
// idle active-low inputs read as released.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: drives active-low column selects, samples the rows at
// each column's terminal count, and debounces whole-scan results into key events.
import key_scan_pkg::*;

module key_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = 4;

    logic [NUM_ROWS-1:0]               rows_s;
    logic [DIV_W-1:0]                  div_cnt;
    logic [1:0]                        col;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0] hit;
    logic                              col_last;
    scan_state_t                       state, state_nxt;
    key_state_t                        candidate, debounced, scan_res;
    logic [CNT_W-1:0]                  stable_cnt, cnt_nxt;
    logic                              accept;

    key_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (row_n),
        .q       (rows_s)
    );

    assign col_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign col_n    = ~(4'b0001 << col);
    assign key_held = debounced.valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            col     <= '0;
            hit     <= '0;
        end else if (col_last) begin
            div_cnt  <= '0;
            hit[col] <= ~rows_s;
            col      <= col + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SCAN: if (col_last && col == 2'd3) state_nxt = ST_EVAL;
            ST_EVAL: state_nxt = ST_SCAN;
            default: state_nxt = ST_SCAN;
        endcase
    end

    // The new candidate is always the scan result; only the count depends on a match.
    always_comb begin
        scan_res = decode_hits(hit);
        if (scan_res == candidate) begin
            cnt_nxt = (stable_cnt == CNT_W'(DEBOUNCE_SCANS)) ? stable_cnt
                                                              : stable_cnt + 1'b1;
        end else begin
            cnt_nxt = CNT_W'(1);
        end
        accept = (cnt_nxt == CNT_W'(DEBOUNCE_SCANS)) && (scan_res != debounced);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            candidate  <= KEY_NONE;
            debounced  <= KEY_NONE;
            stable_cnt <= '0;
            key_code   <= '0;
            key_valid  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (state == ST_EVAL) begin
                candidate  <= scan_res;
                stable_cnt <= cnt_nxt;
                if (accept) begin
                    debounced <= scan_res;
                    if (scan_res.valid) begin
                        key_code  <= scan_res.code;
                        key_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: keypad model, table-driven scan vectors,
// randomized presses against a scan-history reference model, reset corner cases.
module tb_key_scan;

    localparam int SD        = 4;
    localparam int DB        = 2;
    localparam int SCAN      = 4 * SD;
    localparam int TRACE_LEN = 8192;
    localparam int NT        = 11;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          pulses;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int          checks    = 0;
    int          passes    = 0;
    int          edge_n    = 0;
    logic [15:0] trace [TRACE_LEN];
    bit          model_on  = 1'b0;
    int          pulse_cnt = 0;
    int          m_deb     = -1;
    int          m_code    = 0;
    int          hist[$];

    always #5 clock = ~clock;

    key_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Ideal matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            edge_n <= 0;
        end else begin
            edge_n <= edge_n + 1;
            if (edge_n + 1 < TRACE_LEN) trace[edge_n + 1] <= pressed;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Column c of scan n sees the keys held two cycles before its sample edge.
    function automatic int scan_result(input int n);
        int          hits;
        int          k;
        logic [15:0] s;
        hits = 0;
        k    = -1;
        for (int c = 0; c < 4; c++) begin
            s = trace[SCAN*n + SD*c + 2];
            for (int r = 0; r < 4; r++)
                if (s[r*4+c]) begin
                    hits++;
                    k = r*4 + c;
                end
        end
        return (hits == 1) ? k : -1;
    endfunction

    always @(negedge clock) begin : monitor
        bit exp_valid;
        bit same;
        int r;
        exp_valid = 1'b0;
        if (model_on && reset_n) begin
            if (edge_n >= SCAN + 1 && (edge_n - 1) % SCAN == 0) begin
                r = scan_result((edge_n - SCAN - 1) / SCAN);
                hist.push_back(r);
                if (hist.size() > DB) void'(hist.pop_front());
                same = 1'b1;
                foreach (hist[i]) if (hist[i] != r) same = 1'b0;
                if (hist.size() == DB && same && r != m_deb) begin
                    m_deb = r;
                    if (r >= 0) begin
                        m_code    = r;
                        exp_valid = 1'b1;
                    end
                end
            end
            check("model col_n", col_n, 4'hF ^ (4'h1 << ((edge_n / SD) % 4)));
            check("model key_valid", key_valid, exp_valid);
            check("model key_held", key_held, m_deb >= 0);
            check("model key_code", key_code, m_code);
            if (key_valid) pulse_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [NT];
        int   snap, sel, ka, kb, dur, got, found, pulses, first;

        tbl[0]  = '{keys: 16'h0000, scans: 3, pulses: 0, code: 4'd0,  held: 1'b0};
        tbl[1]  = '{keys: 16'h0040, scans: 3, pulses: 1, code: 4'd6,  held: 1'b1};
        tbl[2]  = '{keys: 16'h0000, scans: 3, pulses: 0, code: 4'd6,  held: 1'b0};
        tbl[3]  = '{keys: 16'h8001, scans: 3, pulses: 0, code: 4'd6,  held: 1'b0};
        tbl[4]  = '{keys: 16'h0001, scans: 3, pulses: 1, code: 4'd0,  held: 1'b1};
        tbl[5]  = '{keys: 16'h0020, scans: 3, pulses: 1, code: 4'd5,  held: 1'b1};
        tbl[6]  = '{keys: 16'h0400, scans: 3, pulses: 1, code: 4'd10, held: 1'b1};
        tbl[7]  = '{keys: 16'h0008, scans: 1, pulses: 0, code: 4'd10, held: 1'b1};
        tbl[8]  = '{keys: 16'h0400, scans: 2, pulses: 0, code: 4'd10, held: 1'b1};
        tbl[9]  = '{keys: 16'h0000, scans: 1, pulses: 0, code: 4'd10, held: 1'b1};
        tbl[10] = '{keys: 16'h0000, scans: 2, pulses: 0, code: 4'd10, held: 1'b0};

        reset_n = 1'b0;
        pressed = tbl[0].keys;
        repeat (3) @(negedge clock);
        check("reset col_n", col_n, 4'b1110);
        check("reset key_code", key_code, 0);
        check("reset key_valid", key_valid, 0);
        check("reset key_held", key_held, 0);

        m_deb = -1; m_code = 0; hist.delete(); pulse_cnt = 0; snap = 0;
        model_on = 1'b1;
        #2 reset_n = 1'b1;

        // Scan-aligned vectors: entry i is judged two cycles after its last evaluation.
        for (int i = 0; i < NT; i++) begin
            pressed = tbl[i].keys;
            repeat (2) @(negedge clock);
            if (i > 0) begin
                check($sformatf("vec%0d pulses", i-1), pulse_cnt - snap, tbl[i-1].pulses);
                check($sformatf("vec%0d key_code", i-1), key_code, tbl[i-1].code);
                check($sformatf("vec%0d key_held", i-1), key_held, tbl[i-1].held);
                snap = pulse_cnt;
            end
            repeat (SCAN * tbl[i].scans - 2) @(negedge clock);
        end

        pressed = 16'h0040;
        repeat (2) @(negedge clock);
        check($sformatf("vec%0d pulses", NT-1), pulse_cnt - snap, tbl[NT-1].pulses);
        check($sformatf("vec%0d key_code", NT-1), key_code, tbl[NT-1].code);
        check($sformatf("vec%0d key_held", NT-1), key_held, tbl[NT-1].held);
        repeat (5) @(negedge clock);

        // Bouncing key 6 (7-cycle toggles, unaligned to the scan), then settled.
        for (int k = 1; k < 12; k++) begin
            pressed = (k % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (7) @(negedge clock);
        end
        pressed = 16'h0040;
        repeat (5 * SCAN) @(negedge clock);
        check("bounce key_code", key_code, 6);
        check("bounce key_held", key_held, 1);

        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            ka  = $urandom_range(0, 15);
            kb  = $urandom_range(0, 15);
            dur = $urandom_range(4, 56);
            if (sel < 3)      pressed = '0;
            else if (sel < 8) pressed = 16'(1) << ka;
            else              pressed = (16'(1) << ka) | (16'(1) << kb);
            repeat (dur) @(negedge clock);
        end
        pressed = '0;
        repeat (4 * SCAN) @(negedge clock);
        model_on = 1'b0;

        // Key 15 held across a reset asserted in the middle of column 2.
        @(negedge clock);
        reset_n = 1'b0;
        pressed = 16'h8000;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got == 0; c++) begin
            @(negedge clock);
            if (key_valid) got = 1;
        end
        check("key15 pulse seen", got, 1);
        check("key15 key_code", key_code, 15);
        check("key15 key_held", key_held, 1);

        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clock);
            if (col_n == 4'b1011) found = 1;
        end
        check("reached column 2", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async rst col_n", col_n, 4'b1110);
        check("async rst key_code", key_code, 0);
        check("async rst key_valid", key_valid, 0);
        check("async rst key_held", key_held, 0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;

        pulses = 0;
        first  = -1;
        for (int c = 1; c <= (DB + 1) * SCAN + 4; c++) begin
            @(negedge clock);
            if (c == 3) check("restart col0 held", col_n, 4'b1110);
            if (c == 4) check("restart col1 at 4", col_n, 4'b1101);
            if (key_valid) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        check("fresh pulse within latency", first > 0, 1);
        check("fresh pulse count", pulses, 1);
        check("fresh key_code", key_code, 15);
        check("fresh key_held", key_held, 1);

        pulses = 0;
        repeat (4 * SCAN) begin
            @(negedge clock);
            if (key_valid) pulses++;
        end
        check("held no repeat", pulses, 0);
        check("held key_held", key_held, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
